// File: rtl/bmp_pkg.sv
// Shared definitions for the BMP image pipeline blocks (gray<->BGR converters).
package bmp_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_RD,
    S_HDR_WR,
    S_PIX_RD,
    S_PIX_WR,
    S_PAD_WR,
    S_DONE
  } bmp_state_t;

  localparam int HEADER_SIZE_DEF = 54;
  localparam int CHANNELS        = 3;

  // Zero bytes needed to bring a 24-bit row up to a 4-byte boundary.
  function automatic int row_pad(input int width);
    return (4 - ((CHANNELS * width) % 4)) % 4;
  endfunction

endpackage

// File: rtl/bmp_raster_counter.sv
// Channel / column / pad / row counters walking the output raster of a 24-bit BMP.
module bmp_raster_counter
  import bmp_pkg::*;
#(
  parameter int WIDTH  = 2,
  parameter int HEIGHT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic ch_adv,
  input  logic pad_adv,
  output logic col_last,
  output logic row_last,
  output logic ch_last,
  output logic pad_last
);

  localparam int PAD = row_pad(WIDTH);
  localparam int CW  = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int RW  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [1:0]    ch;
  logic [1:0]    pad;
  logic          pix_done;
  logic          row_end;

  assign ch_last  = (ch  == 2'(CHANNELS - 1));
  assign col_last = (col == CW'(WIDTH - 1));
  assign row_last = (row == RW'(HEIGHT - 1));
  assign pad_last = (PAD == 0) || (pad == 2'(PAD - 1));

  // A row ends on the last channel of the last pixel when there is no pad,
  // otherwise on the last pad byte.
  assign pix_done = ch_adv && ch_last;
  assign row_end  = (pix_done && col_last && (PAD == 0)) || (pad_adv && pad_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch  <= '0;
      col <= '0;
      pad <= '0;
      row <= '0;
    end else if (clr) begin
      ch  <= '0;
      col <= '0;
      pad <= '0;
      row <= '0;
    end else begin
      if (ch_adv)   ch  <= ch_last  ? '0 : ch  + 2'(1);
      if (pix_done) col <= col_last ? '0 : col + CW'(1);
      if (pad_adv)  pad <= pad_last ? '0 : pad + 2'(1);
      if (row_end)  row <= row_last ? '0 : row + RW'(1);
    end
  end

endmodule

// File: rtl/gray_to_bgr.sv
// Expands an 8-bit gray BMP plane from ROM into a padded 24-bit BGR BMP in RAM.
module gray_to_bgr
  import bmp_pkg::*;
#(
  parameter int WIDTH       = 2,
  parameter int HEIGHT      = 2,
  parameter int HEADER_SIZE = HEADER_SIZE_DEF,
  parameter int ADDR_WIDTH  = 16,
  parameter int BYTE_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [BYTE_WIDTH-1:0] ROM_Q,
  output logic                  ROM_valid,
  output logic [ADDR_WIDTH-1:0] ROM_addr,
  output logic                  RAM_valid,
  output logic [BYTE_WIDTH-1:0] RAM_D,
  output logic [ADDR_WIDTH-1:0] RAM_addr,
  output logic                  done
);

  localparam int     PAD       = row_pad(WIDTH);
  localparam longint RAM_FINAL = longint'(HEADER_SIZE) +
                                 longint'(HEIGHT) * longint'(CHANNELS * WIDTH + PAD);

  if ((RAM_FINAL >= (longint'(1) << ADDR_WIDTH)) || (HEADER_SIZE < 1)) begin : g_addr_check
    $error("gray_to_bgr: ADDR_WIDTH too small for the output image or HEADER_SIZE < 1");
  end

  bmp_state_t            state;
  bmp_state_t            state_nx;
  logic [BYTE_WIDTH-1:0] byte_q;
  logic                  start;
  logic                  hdr_last;
  logic                  ch_adv;
  logic                  pad_adv;
  logic                  col_last;
  logic                  row_last;
  logic                  ch_last;
  logic                  pad_last;

  assign start    = (state == S_IDLE) && in_valid;
  // RAM_addr counts header bytes during the header phase since it starts at 0.
  assign hdr_last = (RAM_addr == ADDR_WIDTH'(HEADER_SIZE - 1));

  bmp_raster_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_raster (
    .clk      (clk),
    .rst      (rst),
    .clr      (start),
    .ch_adv   (ch_adv),
    .pad_adv  (pad_adv),
    .col_last (col_last),
    .row_last (row_last),
    .ch_last  (ch_last),
    .pad_last (pad_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (in_valid) state_nx = S_HDR_RD;
      S_HDR_RD: state_nx = S_HDR_WR;
      S_HDR_WR: state_nx = hdr_last ? S_PIX_RD : S_HDR_RD;
      S_PIX_RD: state_nx = S_PIX_WR;
      S_PIX_WR: begin
        if (ch_last) begin
          if (!col_last)     state_nx = S_PIX_RD;
          else if (PAD > 0)  state_nx = S_PAD_WR;
          else if (row_last) state_nx = S_DONE;
          else               state_nx = S_PIX_RD;
        end
      end
      S_PAD_WR: if (pad_last) state_nx = row_last ? S_DONE : S_PIX_RD;
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    ROM_valid = 1'b0;
    RAM_valid = 1'b0;
    RAM_D     = '0;
    done      = 1'b0;
    ch_adv    = 1'b0;
    pad_adv   = 1'b0;
    case (state)
      S_HDR_RD: ROM_valid = 1'b1;
      S_HDR_WR: begin
        RAM_valid = 1'b1;
        RAM_D     = byte_q;
      end
      S_PIX_RD: ROM_valid = 1'b1;
      S_PIX_WR: begin
        RAM_valid = 1'b1;
        RAM_D     = byte_q;
        ch_adv    = 1'b1;
      end
      S_PAD_WR: begin
        RAM_valid = 1'b1;
        pad_adv   = 1'b1;
      end
      S_DONE:   done = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ROM_addr <= '0;
      RAM_addr <= '0;
      byte_q   <= '0;
    end else begin
      if (start) begin
        ROM_addr <= '0;
        RAM_addr <= '0;
      end else begin
        if (ROM_valid) ROM_addr <= ROM_addr + ADDR_WIDTH'(1);
        if (RAM_valid) RAM_addr <= RAM_addr + ADDR_WIDTH'(1);
      end
      if (ROM_valid) byte_q <= ROM_Q;
    end
  end

endmodule

// File: tb/tb_gray_to_bgr.sv
// Bench for gray_to_bgr: three geometries, reset abort, back-to-back runs, write scoreboard.
module tb_gray_to_bgr;

  localparam int N      = 3;
  localparam int HDR    = 54;
  localparam int WS [N] = '{2, 4, 1};
  localparam int HS [N] = '{2, 1, 3};

  typedef struct {
    int a;
    int d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid  [N];
  logic [7:0]  rom_q     [N];
  logic        rom_valid [N];
  logic        ram_valid [N];
  logic        done      [N];
  logic [15:0] rom_addr  [N];
  logic [15:0] ram_addr  [N];
  logic [7:0]  ram_d     [N];
  logic [7:0]  rom       [N][65536];
  logic [7:0]  ram       [N][65536];

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc    = 0;
  int  t_hdr  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < N; g++) begin : g_dut
    assign rom_q[g] = rom[g][rom_addr[g]];
    gray_to_bgr #(
      .WIDTH       (WS[g]),
      .HEIGHT      (HS[g]),
      .HEADER_SIZE (HDR),
      .ADDR_WIDTH  (16),
      .BYTE_WIDTH  (8)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .ROM_Q     (rom_q[g]),
      .ROM_valid (rom_valid[g]),
      .ROM_addr  (rom_addr[g]),
      .RAM_valid (ram_valid[g]),
      .RAM_D     (ram_d[g]),
      .RAM_addr  (ram_addr[g]),
      .done      (done[g])
    );
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int pad_of(input int w);
    return (4 - ((3 * w) % 4)) % 4;
  endfunction

  task automatic push_expected(input int g);
    wr_t e;
    int  a = 0;
    for (int i = 0; i < HDR; i++) begin
      e.a = a; e.d = int'(rom[g][i]); exp_q.push_back(e); a++;
    end
    for (int r = 0; r < HS[g]; r++) begin
      for (int c = 0; c < WS[g]; c++) begin
        for (int k = 0; k < 3; k++) begin
          e.a = a; e.d = int'(rom[g][HDR + r * WS[g] + c]); exp_q.push_back(e); a++;
        end
      end
      for (int p = 0; p < pad_of(WS[g]); p++) begin
        e.a = a; e.d = 0; exp_q.push_back(e); a++;
      end
    end
  endtask

  task automatic start_run(input int g, input bit hold);
    push_expected(g);
    @(negedge clk);
    in_valid[g] = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) in_valid[g] = 1'b0;
    chk("start_rom_valid", int'(rom_valid[g]), 1);
    chk("start_rom_addr", int'(rom_addr[g]), 0);
    t_hdr = cyc;
  endtask

  task automatic wait_done(input int g);
    int w   = WS[g];
    int h   = HS[g];
    int lat = 2 * HDR + h * (4 * w + pad_of(w));
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done[g]) break;
    end
    chk("done_seen", int'(done[g]), 1);
    chk("done_latency", cyc - t_hdr, lat);
    chk("final_rom_addr", int'(rom_addr[g]), HDR + w * h);
    chk("final_ram_addr", int'(ram_addr[g]), HDR + h * (3 * w + pad_of(w)));
    chk("done_no_strobe", int'(rom_valid[g] | ram_valid[g]), 0);
    chk("scoreboard_drained", exp_q.size(), 0);
    @(negedge clk);
    chk("done_width", int'(done[g]), 0);
    chk("idle_no_read", int'(rom_valid[g]), 0);
  endtask

  // Protocol and scoreboard monitor across all instances.
  initial begin
    logic        pv_rom [N];
    logic        pv_ram [N];
    logic [15:0] pa_rom [N];
    logic [15:0] pa_ram [N];
    wr_t         e;
    for (int g = 0; g < N; g++) begin
      pv_rom[g] = 1'b0; pv_ram[g] = 1'b0; pa_rom[g] = '0; pa_ram[g] = '0;
    end
    forever begin
      @(negedge clk);
      for (int g = 0; g < N; g++) begin
        chk("strobe_exclusive", int'(rom_valid[g] & ram_valid[g]), 0);
        if (ram_valid[g]) begin
          chk("write_expected", int'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("write_addr", int'(ram_addr[g]), e.a);
            chk("write_data", int'(ram_d[g]), e.d);
          end
          ram[g][ram_addr[g]] = ram_d[g];
        end else begin
          chk("ram_d_idle_zero", int'(ram_d[g]), 0);
        end
        if (rom_addr[g] != pa_rom[g])
          chk("rom_addr_step", int'(pv_rom[g] || (rom_addr[g] == 16'd0)), 1);
        if (ram_addr[g] != pa_ram[g])
          chk("ram_addr_step", int'(pv_ram[g] || (ram_addr[g] == 16'd0)), 1);
        pv_rom[g] = rom_valid[g];
        pv_ram[g] = ram_valid[g];
        pa_rom[g] = rom_addr[g];
        pa_ram[g] = ram_addr[g];
      end
    end
  end

  initial begin
    bit found;
    rst = 1'b1;
    for (int g = 0; g < N; g++) begin
      in_valid[g] = 1'b0;
      for (int i = 0; i < 256; i++) rom[g][i] = 8'(i);
    end
    rom[0][54] = 8'h10; rom[0][55] = 8'h20; rom[0][56] = 8'h30; rom[0][57] = 8'h40;
    rom[1][54] = 8'hFF; rom[1][55] = 8'h00; rom[1][56] = 8'h80; rom[1][57] = 8'h01;
    rom[2][54] = 8'hA5; rom[2][55] = 8'h5A; rom[2][56] = 8'hC3;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_rom_valid", int'(rom_valid[0]), 0);
    chk("rst_ram_valid", int'(ram_valid[0]), 0);
    chk("rst_done", int'(done[0]), 0);
    chk("rst_rom_addr", int'(rom_addr[0]), 0);
    chk("rst_ram_addr", int'(ram_addr[0]), 0);
    chk("rst_ram_d", int'(ram_d[0]), 0);
    @(negedge clk);
    rst = 1'b0;

    // 2x2 image with 2 pad bytes per row
    start_run(0, 1'b0);
    wait_done(0);
    chk("w2_ram61_pad", int'(ram[0][61]), 0);
    chk("w2_ram65_px", int'(ram[0][65]), 'h40);

    // 4x1 image, rows already 4-byte aligned
    start_run(1, 1'b0);
    wait_done(1);
    chk("w4_ram65_px", int'(ram[1][65]), 'h01);

    // 1x3 image, one pad byte per row
    start_run(2, 1'b0);
    wait_done(2);
    chk("w1_ram57_pad", int'(ram[2][57]), 0);
    chk("w1_ram61_pad", int'(ram[2][61]), 0);
    chk("w1_ram65_pad", int'(ram[2][65]), 0);
    chk("w1_ram60_px", int'(ram[2][60]), 'h5A);

    // Abort in the middle of a pixel write, then a clean rerun
    rom[0][54] = 8'h11; rom[0][55] = 8'h22; rom[0][56] = 8'h33; rom[0][57] = 8'h44;
    start_run(0, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #1;
      if (ram_valid[0] && (ram_addr[0] == 16'd55)) begin
        found = 1'b1;
        break;
      end
    end
    chk("abort_point_reached", int'(found), 1);
    rst = 1'b1;
    #1;
    exp_q.delete();
    chk("abort_ram_valid", int'(ram_valid[0]), 0);
    chk("abort_rom_valid", int'(rom_valid[0]), 0);
    chk("abort_ram_d", int'(ram_d[0]), 0);
    chk("abort_ram_addr", int'(ram_addr[0]), 0);
    chk("abort_rom_addr", int'(rom_addr[0]), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_held_ram_valid", int'(ram_valid[0]), 0);
    @(negedge clk);
    rst = 1'b0;
    start_run(0, 1'b0);
    wait_done(0);

    // in_valid held high across two runs
    start_run(0, 1'b1);
    wait_done(0);
    push_expected(0);
    @(posedge clk);
    #1;
    chk("b2b_restart", int'(rom_valid[0]), 1);
    chk("b2b_rom_addr", int'(rom_addr[0]), 0);
    t_hdr = cyc;
    wait_done(0);
    in_valid[0] = 1'b0;
    @(posedge clk);
    #1;
    chk("no_third_run", int'(rom_valid[0]), 0);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
